// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read SRAM between the instruction-fetch and data ports.
// MEM has priority; a streak counter guarantees IF a grant after MAX_DM_STREAK MEM wins.
module mem_port_arbiter #(
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_dm_req,
   input  logic        i_dm_wr,
   input  logic [31:0] i_dm_addr,
   input  logic [3:0]  i_dm_wen,
   input  logic [31:0] i_dm_wdata,
   output logic        o_dm_gnt,
   output logic        o_dm_rvalid,
   output logic [31:0] o_dm_rdata,
   output logic [31:0] o_ram_addr,
   output logic [3:0]  o_ram_wen,
   output logic [31:0] o_ram_wdata,
   input  logic [31:0] i_ram_rdata,
   output logic        o_ram_ce_n,
   output logic        o_ram_oe_n,
   output logic        o_ram_we_n,
   output logic        o_busy
);

   localparam int unsigned SW = $clog2(MAX_DM_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_t;

   typedef enum logic [0:0] {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   state_t        r_state;
   state_t        w_state_nxt;
   owner_t        r_owner;
   owner_t        w_owner_nxt;
   logic [SW-1:0] r_streak;
   logic [SW-1:0] w_streak_nxt;
   logic          w_if_gnt;
   logic          w_dm_gnt;
   logic          w_rd_gnt;
   logic          w_wr_gnt;

   // Arbitration: only in IDLE and never while reset is asserted.
   always_comb begin
      w_if_gnt = 1'b0;
      w_dm_gnt = 1'b0;
      if (!i_rst && (r_state == ST_IDLE)) begin
         if (i_dm_req && !(i_if_req && (r_streak == STREAK_MAX))) begin
            w_dm_gnt = 1'b1;
         end else if (i_if_req) begin
            w_if_gnt = 1'b1;
         end else begin
            w_if_gnt = 1'b0;
         end
      end else begin
         w_dm_gnt = 1'b0;
      end
      w_rd_gnt = w_if_gnt | (w_dm_gnt & ~i_dm_wr);
      w_wr_gnt = w_dm_gnt & i_dm_wr;
   end

   // Next-state, owner and streak update logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_streak_nxt = r_streak;
      case (r_state)
         ST_IDLE: begin
            if (w_rd_gnt) begin
               w_state_nxt = ST_RD_WAIT;
               w_owner_nxt = w_dm_gnt ? OWN_MEM : OWN_IF;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_if_gnt) begin
         w_streak_nxt = {SW{1'b0}};
      end else if (w_dm_gnt && i_if_req && (r_streak != STREAK_MAX)) begin
         w_streak_nxt = r_streak + SW'(1);
      end else begin
         w_streak_nxt = r_streak;
      end
   end

   // State, owner and streak registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= OWN_IF;
         r_streak <= {SW{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_streak <= w_streak_nxt;
      end
   end

   // SRAM pin drive: the granted payload, otherwise an idle bus.
   always_comb begin
      o_ram_addr  = 32'h0000_0000;
      o_ram_wen   = 4'b0000;
      o_ram_wdata = 32'h0000_0000;
      o_ram_ce_n  = 1'b1;
      o_ram_oe_n  = 1'b1;
      o_ram_we_n  = 1'b1;
      if (w_wr_gnt) begin
         o_ram_addr  = i_dm_addr;
         o_ram_wen   = i_dm_wen;
         o_ram_wdata = i_dm_wdata;
         o_ram_ce_n  = 1'b0;
         o_ram_we_n  = 1'b0;
      end else if (w_rd_gnt) begin
         o_ram_addr = w_dm_gnt ? i_dm_addr : i_if_addr;
         o_ram_ce_n = 1'b0;
         o_ram_oe_n = 1'b0;
      end else begin
         o_ram_ce_n = 1'b1;
      end
   end

   // Response side is derived from registered state; reset masks a pending return.
   always_comb begin
      o_if_gnt    = w_if_gnt;
      o_dm_gnt    = w_dm_gnt;
      o_busy      = (r_state == ST_RD_WAIT);
      o_if_rvalid = !i_rst && (r_state == ST_RD_WAIT) && (r_owner == OWN_IF);
      o_dm_rvalid = !i_rst && (r_state == ST_RD_WAIT) && (r_owner == OWN_MEM);
      o_if_rdata  = i_ram_rdata;
      o_dm_rdata  = i_ram_rdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a behavioural synchronous SRAM on the pins.
// Read expectations come from a bench-side shadow memory updated as stores are issued.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_wr;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [3:0]  dm_wen;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic [31:0] if_rdata, dm_rdata;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_wen;
   logic        ram_ce_n, ram_oe_n, ram_we_n, busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] sram_mem [logic [31:0]];
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] if_q [$];
   logic [31:0] dm_q [$];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_DM_STREAK(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_dm_req(dm_req), .i_dm_wr(dm_wr), .i_dm_addr(dm_addr),
      .i_dm_wen(dm_wen), .i_dm_wdata(dm_wdata),
      .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
      .o_ram_addr(ram_addr), .o_ram_wen(ram_wen), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata),
      .o_ram_ce_n(ram_ce_n), .o_ram_oe_n(ram_oe_n), .o_ram_we_n(ram_we_n),
      .o_busy(busy)
   );

   // Behavioural single-port SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (!ram_ce_n) begin
         if (!ram_we_n) begin
            logic [31:0] w;
            w = sram_mem.exists(ram_addr) ? sram_mem[ram_addr] : 32'h0000_0000;
            for (int b = 0; b < 4; b++)
               if (ram_wen[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
            sram_mem[ram_addr] = w;
         end
         if (!ram_oe_n)
            ram_rdata <= sram_mem.exists(ram_addr) ? sram_mem[ram_addr] : 32'h0000_0000;
      end
   end

   // Scoreboard: every rvalid must match the oldest expected read for that port.
   always @(negedge clk) begin
      #2;
      if (if_rvalid && dm_rvalid) begin
         checks++; errors++;
         $display("FAIL rvalid_overlap: both rvalids high at %0t", $time);
      end
      if (if_rvalid) begin
         checks++;
         if (if_q.size() == 0) begin
            errors++;
            $display("FAIL if_rvalid_unexpected: got rdata %h, required no rvalid", if_rdata);
         end else begin
            logic [31:0] e;
            e = if_q.pop_front();
            if (if_rdata !== e) begin
               errors++;
               $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
            end
         end
      end
      if (dm_rvalid) begin
         checks++;
         if (dm_q.size() == 0) begin
            errors++;
            $display("FAIL dm_rvalid_unexpected: got rdata %h, required no rvalid", dm_rdata);
         end else begin
            logic [31:0] e;
            e = dm_q.pop_front();
            if (dm_rdata !== e) begin
               errors++;
               $display("FAIL dm_rdata: got %h, required %h", dm_rdata, e);
            end
         end
      end
   end

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0000_0000;
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] w;
      w = ref_rd(a);
      for (int b = 0; b < 4; b++)
         if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[a] = w;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      sram_mem[a] = d;
      ref_mem[a]  = d;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      if_addr = 32'h0; dm_addr = 32'h0; dm_wen = 4'h0; dm_wdata = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b1; dm_wen = 4'hF;
      #1;
      checks++;
      if ({if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n, ram_wen} !== {5'b00111, 4'b0000}) begin
         errors++;
         $display("FAIL reset_pins: got gnt=%b%b ce/oe/we=%b%b%b wen=%b, required 00 111 0000",
                  if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n, ram_wen);
      end
      checks++;
      if ({busy, if_rvalid, dm_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: got busy/ifv/dmv=%b%b%b, required 000", busy, if_rvalid, dm_rvalid);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_if_read();
      preload(32'h0000_0010, 32'hDEAD_BEEF);
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_0010;
      #1;
      checks++;
      if ({if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n} !== 5'b10001 || ram_addr !== 32'h10) begin
         errors++;
         $display("FAIL if_read_issue: got gnt=%b%b ce/oe/we=%b%b%b addr=%h, required 10 001 00000010",
                  if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n, ram_addr);
      end
      if_q.push_back(ref_rd(32'h0000_0010));
      @(negedge clk);
      if_req = 1'b0;
      #1;
      checks++;
      if ({if_rvalid, busy, ram_ce_n} !== 3'b111 || if_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL if_read_return: got rvalid/busy/ce_n=%b%b%b rdata=%h, required 111 deadbeef",
                  if_rvalid, busy, ram_ce_n, if_rdata);
      end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h20; dm_wen = 4'b0100; dm_wdata = 32'h00AB_0000;
      #1;
      checks++;
      if ({dm_gnt, ram_ce_n, ram_we_n, ram_oe_n} !== 4'b1001 || ram_wen !== 4'b0100 ||
          ram_wdata !== 32'h00AB_0000 || ram_addr !== 32'h20) begin
         errors++;
         $display("FAIL store_issue: got gnt/ce/we/oe=%b%b%b%b wen=%b wdata=%h addr=%h, required 1001 0100 00ab0000 00000020",
                  dm_gnt, ram_ce_n, ram_we_n, ram_oe_n, ram_wen, ram_wdata, ram_addr);
      end
      ref_wr(32'h20, 4'b0100, 32'h00AB_0000);
      @(negedge clk);
      dm_wr = 1'b0; dm_wen = 4'hF; dm_wdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({dm_gnt, ram_oe_n, ram_we_n} !== 3'b101 || ram_wen !== 4'b0000) begin
         errors++;
         $display("FAIL load_issue: got gnt/oe/we=%b%b%b wen=%b, required 101 0000",
                  dm_gnt, ram_oe_n, ram_we_n, ram_wen);
      end
      dm_q.push_back(ref_rd(32'h20));
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h00AB_0000) begin
         errors++;
         $display("FAIL load_return: got rvalid=%b rdata=%h, required 1 00ab0000", dm_rvalid, dm_rdata);
      end
   endtask

   // Drives one cycle of IF-read + MEM-store contention; code 1 = MEM, 2 = IF, 0 = no grant.
   task automatic contend_cycle(input string name, input int code, inout int k);
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_wr = 1'b1; dm_wen = 4'hF;
      dm_addr = 32'h100 + 32'(k) * 32'h4; dm_wdata = 32'hA000_0000 + 32'(k);
      #1;
      checks++;
      if (dm_gnt !== (code == 1) || if_gnt !== (code == 2)) begin
         errors++;
         $display("FAIL %s: got if/dm gnt=%b%b, required %b%b", name, if_gnt, dm_gnt,
                  code == 2, code == 1);
      end
      if (code == 1) begin
         ref_wr(dm_addr, dm_wen, dm_wdata);
         k++;
      end else if (code == 2) begin
         if_q.push_back(ref_rd(32'h40));
      end
   endtask

   task automatic test_streak();
      int pat [12] = '{1, 1, 1, 1, 2, 0, 1, 1, 1, 1, 2, 0};
      int k = 0;
      preload(32'h40, 32'h1234_5678);
      for (int c = 0; c < 12; c++) contend_cycle("streak_pattern", pat[c], k);
      @(negedge clk);
      idle_inputs();
      dm_req = 1'b1; dm_addr = 32'h104;
      #1;
      checks++;
      if (dm_gnt !== 1'b1) begin
         errors++;
         $display("FAIL streak_readback_gnt: got %b, required 1", dm_gnt);
      end
      dm_q.push_back(ref_rd(32'h104));
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_simultaneous_loads();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h20;
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL simul_first: got if/dm gnt=%b%b, required 01", if_gnt, dm_gnt);
      end
      dm_q.push_back(ref_rd(32'h20));
      @(negedge clk);
      dm_req = 1'b0;
      #1;
      checks++;
      if ({if_gnt, dm_gnt, dm_rvalid, if_rvalid} !== 4'b0010) begin
         errors++;
         $display("FAIL simul_wait: got gnt=%b%b dmv/ifv=%b%b, required 00 10", if_gnt, dm_gnt, dm_rvalid, if_rvalid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if_gnt, dm_gnt, ram_addr} !== {2'b10, 32'h10}) begin
         errors++;
         $display("FAIL simul_second: got gnt=%b%b addr=%h, required 10 00000010", if_gnt, dm_gnt, ram_addr);
      end
      if_q.push_back(ref_rd(32'h10));
      @(negedge clk);
      if_req = 1'b0;
      #1;
      checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b10) begin
         errors++;
         $display("FAIL simul_if_return: got ifv/dmv=%b%b, required 10", if_rvalid, dm_rvalid);
      end
   endtask

   task automatic test_reset_in_rd_wait();
      @(negedge clk);
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h20;
      #1;
      checks++;
      if (dm_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rstwait_issue: got dm_gnt=%b, required 1", dm_gnt);
      end
      @(negedge clk);
      rst = 1'b1; dm_req = 1'b0;
      #1;
      checks++;
      if ({dm_rvalid, if_rvalid, if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n, ram_wen} !== {7'b0000111, 4'b0000}) begin
         errors++;
         $display("FAIL rstwait_masked: got rv=%b%b gnt=%b%b ce/oe/we=%b%b%b wen=%b, required 00 00 111 0000",
                  dm_rvalid, if_rvalid, if_gnt, dm_gnt, ram_ce_n, ram_oe_n, ram_we_n, ram_wen);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, dm_rvalid, if_rvalid, ram_ce_n} !== 4'b0001) begin
         errors++;
         $display("FAIL rstwait_after: got busy/dmv/ifv/ce_n=%b%b%b%b, required 0001", busy, dm_rvalid, if_rvalid, ram_ce_n);
      end
      @(negedge clk);
      dm_req = 1'b1; dm_addr = 32'h20;
      #1;
      checks++;
      if (dm_gnt !== 1'b1 || ram_oe_n !== 1'b0) begin
         errors++;
         $display("FAIL rstwait_regrant: got gnt/oe_n=%b%b, required 10", dm_gnt, ram_oe_n);
      end
      dm_q.push_back(ref_rd(32'h20));
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_idle_bus();
      int k = 8;
      for (int c = 0; c < 3; c++) contend_cycle("idle_prestreak", 1, k);
      @(negedge clk);
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({ram_ce_n, if_rvalid, dm_rvalid, if_gnt, dm_gnt} !== 5'b10000) begin
            errors++;
            $display("FAIL idle_bus: got ce_n/ifv/dmv/gnt=%b%b%b%b%b, required 10000",
                     ram_ce_n, if_rvalid, dm_rvalid, if_gnt, dm_gnt);
         end
      end
      contend_cycle("idle_streak_held_mem", 1, k);
      contend_cycle("idle_streak_held_if", 2, k);
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      ram_rdata = 32'h0000_0000;
      test_reset();
      test_if_read();
      test_store_load();
      test_streak();
      test_simultaneous_loads();
      test_reset_in_rd_wait();
      test_idle_bus();
      repeat (3) @(negedge clk);
      checks++;
      if (if_q.size() != 0 || dm_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d IF and %0d MEM reads outstanding, required 0 and 0",
                  if_q.size(), dm_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
